// File: rtl/fetch_ctrl.sv
// Instruction fetch control: PC sequencing, 2-entry fetch buffer, redirect and halt.
// Optional FETCH_PERF_EN adds saturating stall/flush performance counters.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC  = 16'd0,
  parameter int          MEM_BYTES = 100
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc,
`ifdef FETCH_PERF_EN
  output logic [15:0] perf_stall,
  output logic [15:0] perf_flush,
`endif
  output logic        err_misalign
);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_HALT
  } state_t;

  state_t      state, state_nx;
  logic [15:0] pc;
  logic [16:0] pc_sum;
  logic [15:0] pc_inc;
  logic [15:0] buf_instr [2];
  logic [15:0] buf_pc    [2];
  logic        head;
  logic        tail;
  logic [1:0]  count;
  logic        flush;
  logic        push;
  logic        pop;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_INIT:  state_nx = S_RUN;
      S_RUN:   if (halt) state_nx = S_HALT;
      S_HALT:  if (!halt) state_nx = S_RUN;
      default: state_nx = S_INIT;
    endcase
  end

  // A redirect outranks everything else that would touch the buffer.
  assign flush = br_taken && (state != S_INIT);
  assign push  = (state == S_RUN) && !halt &&
                 (count < 2'd2) && !flush;
  assign pop   = out_valid && out_ready && !flush;
  assign tail  = head ^ count[0];

  assign pc_sum = {1'b0, pc} + 17'd2;
  assign pc_inc = (pc_sum >= 17'(MEM_BYTES)) ?
                  16'd0 : pc_sum[15:0];

  assign imem_addr = (state == S_INIT) ? RESET_PC : pc;
  assign out_valid = (count != 2'd0);
  assign out_instr = buf_instr[head];
  assign out_pc    = buf_pc[head];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_INIT;
      pc           <= RESET_PC;
      head         <= 1'b0;
      count        <= 2'd0;
      err_misalign <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_instr[i] <= 16'd0;
        buf_pc[i]    <= 16'd0;
      end
    end else begin
      state <= state_nx;
      if (flush) begin
        count <= 2'd0;
        pc    <= {br_target[15:1], 1'b0};
        if (br_target[0]) err_misalign <= 1'b1;
      end else begin
        if (push) begin
          buf_instr[tail] <= imem_data;
          buf_pc[tail]    <= pc;
          pc              <= pc_inc;
        end
        if (pop) head <= ~head;
        unique case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall <= 16'd0;
      perf_flush <= 16'd0;
    end else begin
      if (out_valid && !out_ready && perf_stall != 16'hFFFF)
        perf_stall <= perf_stall + 16'd1;
      if (flush && perf_flush != 16'hFFFF)
        perf_flush <= perf_flush + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: startup, redirect, backpressure,
// misaligned branch, wrap, halt drain and mid-run reset.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        br_taken;
  logic [15:0] br_target;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        err_misalign;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_stall;
  logic [15:0] perf_flush;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  fetch_ctrl #(
    .RESET_PC  (16'd0),
    .MEM_BYTES (100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .halt         (halt),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
`ifdef FETCH_PERF_EN
    .perf_stall   (perf_stall),
    .perf_flush   (perf_flush),
`endif
    .err_misalign (err_misalign)
  );

  always #5 clk = ~clk;

  // Memory image: each word tags its own address.
  assign imem_data = 16'hA000 | imem_addr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag,
                          input logic [15:0] pc);
    check({tag, "_valid"}, 16'(out_valid), 16'd1);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_instr"}, out_instr, 16'hA000 | pc);
  endtask

  initial begin
    reset     = 1'b1;
    br_taken  = 1'b0;
    br_target = 16'd0;
    halt      = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_valid", 16'(out_valid), 16'd0);
    check("rst_pc", out_pc, 16'd0);
    check("rst_instr", out_instr, 16'd0);
    check("rst_err", 16'(err_misalign), 16'd0);
    check("rst_addr", imem_addr, 16'd0);

    // Straight line
    reset     = 1'b0;
    out_ready = 1'b1;
    step();
    check("init_valid", 16'(out_valid), 16'd0);
    check("init_addr", imem_addr, 16'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_head("seq", 16'(2 * i));
    end

    // Redirect while pc=6
    check("pre_br_addr", imem_addr, 16'd6);
    br_taken  = 1'b1;
    br_target = 16'h000C;
    step();
    br_taken = 1'b0;
    check("br_valid", 16'(out_valid), 16'd0);
    check("br_addr", imem_addr, 16'd12);
    step();
    chk_head("br1", 16'd12);
    step();
    chk_head("br2", 16'd14);

    // Backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk_head("bp_hold", 16'd14);
    check("bp_addr", imem_addr, 16'd18);
    out_ready = 1'b1;
    step();
    chk_head("bp1", 16'd16);
    step();
    chk_head("bp2", 16'd18);
    step();
    chk_head("bp3", 16'd20);

    // Misaligned redirect
    br_taken  = 1'b1;
    br_target = 16'h0009;
    step();
    br_taken = 1'b0;
    check("mis_valid", 16'(out_valid), 16'd0);
    check("mis_err", 16'(err_misalign), 16'd1);
    check("mis_addr", imem_addr, 16'd8);
    step();
    chk_head("mis1", 16'd8);
    step();
    chk_head("mis2", 16'd10);
    check("mis_sticky", 16'(err_misalign), 16'd1);

    // Wrap past 98
    br_taken  = 1'b1;
    br_target = 16'd96;
    step();
    br_taken = 1'b0;
    step();
    chk_head("wrap96", 16'd96);
    step();
    chk_head("wrap98", 16'd98);
    step();
    chk_head("wrap0", 16'd0);

    // Fill to two entries, then halt and drain
    out_ready = 1'b0;
    step();
    halt = 1'b1;
    step();
    chk_head("halt_full", 16'd0);
    check("halt_addr0", imem_addr, 16'd4);
    out_ready = 1'b1;
    step();
    chk_head("drain1", 16'd2);
    check("halt_addr1", imem_addr, 16'd4);
    step();
    check("drain_empty", 16'(out_valid), 16'd0);
    step();
    check("halt_idle", 16'(out_valid), 16'd0);
    check("halt_addr2", imem_addr, 16'd4);

    // Redirect inside halt stays halted
    br_taken  = 1'b1;
    br_target = 16'h0020;
    step();
    br_taken = 1'b0;
    check("hbr_addr", imem_addr, 16'd32);
    step();
    check("hbr_valid", 16'(out_valid), 16'd0);
    check("hbr_err", 16'(err_misalign), 16'd1);
    halt = 1'b0;
    step();
    check("resume_valid", 16'(out_valid), 16'd0);
    step();
    chk_head("resume", 16'd32);

    // Mid-run reset
    reset = 1'b1;
    step();
    check("mrst_valid", 16'(out_valid), 16'd0);
    check("mrst_pc", out_pc, 16'd0);
    check("mrst_instr", out_instr, 16'd0);
    check("mrst_err", 16'(err_misalign), 16'd0);
    check("mrst_addr", imem_addr, 16'd0);
`ifdef FETCH_PERF_EN
    check("perf_stall", perf_stall, 16'd0);
    check("perf_flush", perf_flush, 16'd0);
`endif
    // Redirect during S_INIT must be ignored
    reset     = 1'b0;
    br_taken  = 1'b1;
    br_target = 16'h0041;
    step();
    br_taken = 1'b0;
    check("ign_valid", 16'(out_valid), 16'd0);
    check("ign_addr", imem_addr, 16'd0);
    check("ign_err", 16'(err_misalign), 16'd0);
    step();
    chk_head("post_rst", 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
